// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues synchronous ROM requests and
// buffers returned instructions for decode under a valid/ready handshake.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic          inflight;
    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          push;

    // Credit check counts the in-flight response so a push can never hit a full buffer
    always_comb begin
        inst_valid_o = (count != '0) && !jump_en_i;
        pop          = inst_valid_o && inst_ready_i;
        push         = inflight && !jump_en_i;
        occupancy    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        rom_req_o    = rst && !jump_en_i && !hold_i && (occupancy < (CW+1)'(DEPTH));
        rom_addr_o   = pc;
        inst_o       = inst_valid_o ? buf_data[rd_ptr] : NOP_INST;
        inst_addr_o  = inst_valid_o ? buf_addr[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_ADDR;
            req_addr <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (jump_en_i) begin
            pc       <= jump_addr_i;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= rom_req_o;
            if (rom_req_o) begin
                pc       <= pc + 32'd4;
                req_addr <= pc;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= req_addr;
            buf_data[wr_ptr] <= rom_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && (count == CW'(DEPTH))));
        end
    end

endmodule
